spike_train_decoder: RTL
========================

Name: spike_train_decoder

Overview:
Receiving end of the neuron spike interface. Consumes the one-cycle spike pulse that izhikevich_neuron emits on each firing event (v crossing the peak). Over fixed windows of simulation steps it measures spike count and inter-spike interval (ISI) statistics, then hands a result record downstream over a valid/ready handshake. It sits between the neuron array and the logger or classifier, and distinguishes firing dynamics such as RS, IB, CH and FS by rate and ISI.

Parameters:
WINDOW, 1000, window length in clk cycles (one cycle = one DT step); legal range 2..2^CNT_W-1
CNT_W, 16, width of the spike count and the window counter
ISI_W, 16, width of the ISI fields; the value 2^ISI_W-1 means "none or saturated"
DROP_W, 8, width of the dropped-window counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0, sampled on the clk rising edge)
en  in  1  enables measurement; a 0 aborts the current window
spike  in  1  firing pulse from the neuron, one cycle per spike; a level held high counts once per cycle
out_valid  out  1  result record available
out_ready  in  1  downstream accepts the record
out_count  out  CNT_W  spikes in the window (saturating)
out_isi_min  out  ISI_W  smallest ISI completed in the window
out_isi_last  out  ISI_W  most recent ISI completed in the window
out_drop  out  DROP_W  windows lost since reset (saturating)

Behaviour:
- Reset (rst=0 at an edge):
  - All outputs are 0, except out_isi_min and out_isi_last, which are all-ones.
  - The FSM goes to IDLE and the ISI history is cleared.
- FSM states:
  - IDLE to RUN when en=1.
  - RUN to IDLE when en=0. The partial window is discarded, the window counter and ISI history are cleared, and a pending output record is kept.
- Window counter: starts at 0 on the first RUN cycle and counts 0..WINDOW-1. The cycle at WINDOW-1 is the close cycle. The counter wraps to 0 on the next cycle and the next window follows with no gap.
- Spike on the close cycle: it is counted and ISI-updated in the closing window.
- ISI timer:
  - Counts cycles since the last spike and saturates at all-ones.
  - ISI = t2 - t1 for spikes at cycles t1 and t2.
  - The timer runs across window boundaries. A window's first ISI can therefore span the previous window.
  - The first spike after reset or after leaving IDLE produces no ISI.
- Window statistics:
  - isi_min is reloaded to all-ones at the start of each window and updated with min().
  - isi_last holds the latest completed ISI in the window, or all-ones if there is none.
  - The spike count saturates at 2^CNT_W-1.
- Snapshot at the close cycle:
  - If the output slot is empty, or out_valid && out_ready in that same cycle, the record is registered.
  - out_valid is 1 on the following cycle. Latency is 1 cycle from the close cycle.
  - Otherwise the record is discarded, out_drop increments (saturating), and the held record is left unchanged.
- Handshake:
  - The record and out_valid stay stable until out_ready=1 while out_valid=1.
  - out_valid drops the cycle after acceptance unless a new snapshot loads in that same cycle, in which case out_valid stays 1 with the new data.
- en=0 on the close cycle: the window is discarded with no snapshot and no drop.
- Reset mid-window or mid-handshake: immediate return to reset values. The pending record is lost and not counted as dropped.
- All arithmetic is unsigned integer. No floating point is used in this block.

Decomposition:
- neuron_pkg holds:
  - spike_stats_t, a packed struct of count, isi_min and isi_last;
  - the enum dyn_t {RS, IB, CH, FS, TC, RZ, LTS}, shared with the bench parameter tables;
  - the constant ISI_NONE (all-ones).
- One sub-module, isi_timer: saturating cycles-since-spike counter with a have_prev flag and an isi_valid/isi_value output.

Test Plan:
- WINDOW=16, en=1 from cycle 0, spikes at cycles 3, 7, 12, out_ready=1 -> at cycle 16: out_valid=1, count=3, isi_min=4, isi_last=5, drop=0.
- Window 2 (cycles 16-31) with a single spike at 18, following the spike at 12 -> count=1, isi_min=6, isi_last=6.
- Window 3 (cycles 32-47) with no spikes -> count=0, isi_min=isi_last=0xFFFF, out_valid pulses for 1 cycle.
- out_ready=0 for 3 windows of bursts -> the first record is held unchanged, drop=2. Then out_ready=1 -> the record is accepted and out_valid falls the next cycle.
- Spike on the close cycle (15) and on cycle 16 -> the cycle-15 spike is counted in window 1, and window 2 reports isi_last=1.
- en=0 at cycle 10 then en=1 at cycle 20 -> no record for the partial window, the first spike after restart gives no ISI, and the new window starts at cycle 20.
- rst=0 at cycle 9 mid-window with a pending record -> all outputs return to reset values at cycle 10.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types for the neuron spike interface.
// Stats record, firing-dynamics labels and the ISI "none" marker.
package neuron_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int ISI_W_DEF  = 16;
    localparam int DROP_W_DEF = 8;

    localparam logic [ISI_W_DEF-1:0] ISI_NONE = '1;

    typedef enum logic [2:0] {
        RS, IB, CH, FS, TC, RZ, LTS
    } dyn_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] count;
        logic [ISI_W_DEF-1:0] isi_min;
        logic [ISI_W_DEF-1:0] isi_last;
    } spike_stats_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } dec_state_t;

endpackage

// File: rtl/spike_train_decoder_if.sv
// Result-record valid/ready channel of the spike train decoder.
// The decoder drives the master side; logger/classifier is the slave.
interface spike_train_decoder_if #(
    parameter int CNT_W  = 16,
    parameter int ISI_W  = 16,
    parameter int DROP_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic [ISI_W-1:0]  out_isi_min;
    logic [ISI_W-1:0]  out_isi_last;
    logic [DROP_W-1:0] out_drop;

    modport master (
        output out_valid,
        input  out_ready,
        output out_count,
        output out_isi_min,
        output out_isi_last,
        output out_drop
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_count,
        input  out_isi_min,
        input  out_isi_last,
        input  out_drop
    );
endinterface

// File: rtl/isi_timer.sv
// Saturating cycles-since-last-spike counter.
// Reports an ISI on every spike that has a predecessor.
module isi_timer #(
    parameter int ISI_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             spike_i,
    output logic             isi_valid_o,
    output logic [ISI_W-1:0] isi_value_o
);

    localparam logic [ISI_W-1:0] SAT = '1;

    logic [ISI_W-1:0] cnt_q, cnt_d;
    logic             have_q, have_d;

    // cnt_q equals t - t_last during cycle t
    assign isi_valid_o = spike_i && have_q && !clr_i;
    assign isi_value_o = cnt_q;

    always_comb begin
        cnt_d  = cnt_q;
        have_d = have_q;
        if (clr_i) begin
            cnt_d  = SAT;
            have_d = 1'b0;
        end else if (spike_i) begin
            cnt_d  = {{(ISI_W-1){1'b0}}, 1'b1};
            have_d = 1'b1;
        end else if (cnt_q != SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= SAT;
            have_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            have_q <= have_d;
        end
    end

endmodule

// File: rtl/spike_train_decoder.sv
// Windowed spike-count / ISI statistics over a neuron spike pulse.
// One record per closed window, offered on a valid/ready channel.
module spike_train_decoder
    import neuron_pkg::*;
#(
    parameter int WINDOW = 1000,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int ISI_W  = ISI_W_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic spike,
    spike_train_decoder_if.master res
);

    localparam logic [CNT_W-1:0]  WIN_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [ISI_W-1:0]  NONE     = '1;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    dec_state_t state_q, state_d;

    logic [CNT_W-1:0] win_q, win_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ISI_W-1:0] min_q, min_d;
    logic [ISI_W-1:0] last_q, last_d;

    logic              vld_q, vld_d;
    logic [CNT_W-1:0]  oc_q, oc_d;
    logic [ISI_W-1:0]  om_q, om_d;
    logic [ISI_W-1:0]  ol_q, ol_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic             spk;
    logic             close;
    logic             isi_v;
    logic [ISI_W-1:0] isi;
    logic [CNT_W-1:0] b_cnt, c_cnt;
    logic [ISI_W-1:0] b_min, c_min;
    logic [ISI_W-1:0] b_last, c_last;
    logic             accept;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (en)  state_d = ST_RUN;
            ST_RUN:  if (!en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Leaving (or sitting in) IDLE forgets the previous spike
    isi_timer #(.ISI_W(ISI_W)) u_isi (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (state_d == ST_IDLE),
        .spike_i     (spk),
        .isi_valid_o (isi_v),
        .isi_value_o (isi)
    );

    assign spk    = en && spike;
    assign close  = en && (win_q == WIN_LAST);
    assign accept = vld_q && res.out_ready;

    always_comb begin
        b_cnt  = cnt_q;
        b_min  = min_q;
        b_last = last_q;
        if (win_q == '0) begin
            b_cnt  = '0;
            b_min  = NONE;
            b_last = NONE;
        end
        c_cnt  = b_cnt;
        c_min  = b_min;
        c_last = b_last;
        if (spk && (b_cnt != CNT_MAX)) c_cnt = b_cnt + 1'b1;
        if (isi_v) begin
            c_last = isi;
            if (isi < b_min) c_min = isi;
        end
    end

    always_comb begin
        win_d  = '0;
        cnt_d  = '0;
        min_d  = NONE;
        last_d = NONE;
        if (en) begin
            win_d  = close ? '0 : win_q + 1'b1;
            cnt_d  = c_cnt;
            min_d  = c_min;
            last_d = c_last;
        end
    end

    always_comb begin
        vld_d  = vld_q;
        oc_d   = oc_q;
        om_d   = om_q;
        ol_d   = ol_q;
        drop_d = drop_q;
        if (accept) vld_d = 1'b0;
        if (close) begin
            if (!vld_q || accept) begin
                vld_d = 1'b1;
                oc_d  = c_cnt;
                om_d  = c_min;
                ol_d  = c_last;
            end else if (drop_q != DROP_MAX) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            cnt_q   <= '0;
            min_q   <= NONE;
            last_q  <= NONE;
            vld_q   <= 1'b0;
            oc_q    <= '0;
            om_q    <= NONE;
            ol_q    <= NONE;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            last_q  <= last_d;
            vld_q   <= vld_d;
            oc_q    <= oc_d;
            om_q    <= om_d;
            ol_q    <= ol_d;
            drop_q  <= drop_d;
        end
    end

    assign res.out_valid    = vld_q;
    assign res.out_count    = oc_q;
    assign res.out_isi_min  = om_q;
    assign res.out_isi_last = ol_q;
    assign res.out_drop     = drop_q;

endmodule
